// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads one word per cycle from a combinational
// instruction memory, buffers {pc, instr} in a small circular queue and hands it to decode.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 2,
  parameter int          MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        halted,
  output logic        misalign_err,
  output logic        range_err,
  output logic [31:0] fetch_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(DEPTH);
  localparam logic [31:0]      MEM_WORDS_C = 32'(MEM_WORDS);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              misalign_q, misalign_d;
  logic              range_q, range_d;
  logic [31:0]       fetch_count_q, fetch_count_d;
  logic [31:0]       q_instr_q [DEPTH];
  logic [31:0]       q_instr_d [DEPTH];
  logic [31:0]       q_pc_q    [DEPTH];
  logic [31:0]       q_pc_d    [DEPTH];

  logic pop_s;
  logic oor_s;
  logic attempt_s;
  logic push_s;

  assign out_valid = (count_q != {CNT_W{1'b0}});
  // A head is only consumed when no redirect is flushing the queue this cycle.
  assign pop_s     = out_valid && out_ready && !redirect_valid;
  assign oor_s     = ({2'b00, pc_q[31:2]} >= MEM_WORDS_C);
  assign attempt_s = (state_q == ST_RUN) && fetch_en && !redirect_valid &&
                     ((count_q < DEPTH_C) || pop_s);
  assign push_s    = attempt_s && !oor_s && (imem_data != 32'h0000_0000);

  assign imem_addr    = pc_q;
  assign out_instr    = out_valid ? q_instr_q[rd_ptr_q] : 32'h0000_0000;
  assign out_pc       = out_valid ? q_pc_q[rd_ptr_q]    : 32'h0000_0000;
  assign halted       = (state_q == ST_HALT);
  assign misalign_err = misalign_q;
  assign range_err    = range_q;
  assign fetch_count  = fetch_count_q;

  // Next-state computation for PC, FSM, queue and status flags.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    misalign_d    = misalign_q;
    range_d       = range_q;
    fetch_count_d = fetch_count_q;
    q_instr_d     = q_instr_q;
    q_pc_d        = q_pc_q;

    if (redirect_valid) begin
      // Redirect wins over everything: flush, restart at the aligned target.
      state_d  = ST_RUN;
      pc_d     = {redirect_target[31:2], 2'b00};
      rd_ptr_d = {PTR_W{1'b0}};
      wr_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
      if (redirect_target[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end else begin
        misalign_d = misalign_q;
      end
    end else begin
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      if (push_s) begin
        q_instr_d[wr_ptr_q] = imem_data;
        q_pc_d[wr_ptr_q]    = pc_q;
        wr_ptr_d            = wr_ptr_q + PTR_W'(1'b1);
        pc_d                = pc_q + 32'd4;
        fetch_count_d       = fetch_count_q + 32'd1;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);

      // A failed attempt parks the FSM with pc still pointing at the offending word.
      case (state_q)
        ST_RUN: begin
          if (attempt_s && !push_s) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_HALT;
      endcase

      if (attempt_s && oor_s) begin
        range_d = 1'b1;
      end else begin
        range_d = range_q;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      rd_ptr_q      <= {PTR_W{1'b0}};
      wr_ptr_q      <= {PTR_W{1'b0}};
      count_q       <= {CNT_W{1'b0}};
      misalign_q    <= 1'b0;
      range_q       <= 1'b0;
      fetch_count_q <= 32'h0000_0000;
      for (int i = 0; i < DEPTH; i++) begin
        q_instr_q[i] <= 32'h0000_0000;
        q_pc_q[i]    <= 32'h0000_0000;
      end
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      misalign_q    <= misalign_d;
      range_q       <= range_d;
      fetch_count_q <= fetch_count_d;
      q_instr_q     <= q_instr_d;
      q_pc_q        <= q_pc_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus randomized
// traffic compared against a queue-based behavioural model.
module tb_instruction_fetch_unit;

  localparam int          DEPTH     = 2;
  localparam int          MEM_WORDS = 1024;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_en = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        halted;
  logic        misalign_err;
  logic        range_err;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:MEM_WORDS-1];

  always #5 clk = ~clk;

  // Out-of-range addresses return junk so the DUT must rely on its range check.
  assign imem_data = (imem_addr[31:12] == 20'h0) ? mem[imem_addr[11:2]] : 32'hDEAD_BEEF;

  instruction_fetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH),
    .MEM_WORDS(MEM_WORDS)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .halted         (halted),
    .misalign_err   (misalign_err),
    .range_err      (range_err),
    .fetch_count    (fetch_count)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [63:0] m_q[$];
  bit          m_halt, m_mis, m_rng;
  logic [31:0] m_cnt;

  function automatic logic [31:0] mem_at(input logic [31:0] a);
    if ((a / 4) < MEM_WORDS) return mem[a / 4];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC;
    m_q.delete();
    m_halt = 0; m_mis = 0; m_rng = 0;
    m_cnt = 32'h0;
  endtask

  task automatic model_edge(input bit fe, input bit rdy, input bit rv, input logic [31:0] tgt);
    bit pop, can;
    logic [31:0] data;
    if (rv) begin
      m_q.delete();
      m_pc = {tgt[31:2], 2'b00};
      m_halt = 0;
      if (tgt[1:0] != 2'b00) m_mis = 1;
    end else begin
      pop  = (m_q.size() > 0) && rdy;
      can  = !m_halt && fe && ((m_q.size() < DEPTH) || pop);
      data = mem_at(m_pc);
      if (pop) void'(m_q.pop_front());
      if (can) begin
        if ((m_pc / 4) >= MEM_WORDS) begin
          m_halt = 1; m_rng = 1;
        end else if (data == 32'h0) begin
          m_halt = 1;
        end else begin
          m_q.push_back({m_pc, data});
          m_pc  = m_pc + 32'd4;
          m_cnt = m_cnt + 32'd1;
        end
      end
    end
  endtask

  task automatic step(input bit fe, input bit rdy, input bit rv, input logic [31:0] tgt);
    fetch_en = fe; out_ready = rdy; redirect_valid = rv; redirect_target = tgt;
    model_edge(fe, rdy, rv, tgt);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    fetch_en = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic load_prog();
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h0;
    mem[0] = 32'hF840_0281; mem[1] = 32'h8B01_0022;
    mem[2] = 32'hD100_6733; mem[3] = 32'hB400_00E3;
  endtask

  task automatic test_reset();
    load_prog();
    do_reset();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_vec++; if (out_pc !== 32'h0 || out_instr !== 32'h0) begin n_err++; $display("FAIL reset_head got %h/%h want 0/0", out_pc, out_instr); end
    n_vec++; if ({halted, misalign_err, range_err} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b want 000", {halted, misalign_err, range_err}); end
    n_vec++; if (fetch_count !== 32'h0 || imem_addr !== RESET_PC) begin n_err++; $display("FAIL reset_cnt_pc got %0d/%h want 0/%h", fetch_count, imem_addr, RESET_PC); end
  endtask

  task automatic test_sequential();
    logic [31:0] prog [4];
    prog[0] = 32'hF840_0281; prog[1] = 32'h8B01_0022; prog[2] = 32'hD100_6733; prog[3] = 32'hB400_00E3;
    load_prog();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      n_vec++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_instr !== prog[i]) begin
        n_err++; $display("FAIL seq_head%0d got v=%b pc=%h i=%h want v=1 pc=%h i=%h", i, out_valid, out_pc, out_instr, 32'(4 * i), prog[i]);
      end
    end
    step(1'b1, 1'b1, 1'b0, 32'h0);
    n_vec++; if (halted !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL seq_halt got h=%b v=%b want h=1 v=0", halted, out_valid); end
    n_vec++; if (imem_addr !== 32'h10 || fetch_count !== 32'd4 || range_err !== 1'b0) begin
      n_err++; $display("FAIL seq_end got pc=%h cnt=%0d rng=%b want 10/4/0", imem_addr, fetch_count, range_err);
    end
  endtask

  task automatic test_backpressure();
    load_prog();
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    n_vec++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin n_err++; $display("FAIL bp_head got v=%b pc=%h want 1/0", out_valid, out_pc); end
    n_vec++; if (imem_addr !== 32'h8 || fetch_count !== 32'd2) begin n_err++; $display("FAIL bp_hold got pc=%h cnt=%0d want 8/2", imem_addr, fetch_count); end
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_instr !== mem[k]) begin
        n_err++; $display("FAIL bp_drain%0d got v=%b pc=%h i=%h want 1/%h/%h", k, out_valid, out_pc, out_instr, 32'(4 * k), mem[k]);
      end
      step(1'b1, 1'b1, 1'b0, 32'h0);
    end
  endtask

  task automatic test_redirect_flush();
    load_prog();
    for (int i = 16; i < 20; i++) mem[i] = 32'h1000_0000 + 32'(i);
    do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h40);
    n_vec++; if (out_valid !== 1'b0 || imem_addr !== 32'h40) begin n_err++; $display("FAIL redir_flush got v=%b pc=%h want 0/40", out_valid, imem_addr); end
    step(1'b1, 1'b1, 1'b0, 32'h0);
    n_vec++; if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== 32'h1000_0010) begin
      n_err++; $display("FAIL redir_first got v=%b pc=%h i=%h want 1/40/10000010", out_valid, out_pc, out_instr);
    end
    step(1'b1, 1'b1, 1'b0, 32'h0);
    n_vec++; if (out_pc !== 32'h44) begin n_err++; $display("FAIL redir_next got pc=%h want 44", out_pc); end
  endtask

  task automatic test_misalign();
    step(1'b1, 1'b1, 1'b1, 32'h42);
    n_vec++; if (misalign_err !== 1'b1 || imem_addr !== 32'h40) begin n_err++; $display("FAIL mis_set got m=%b pc=%h want 1/40", misalign_err, imem_addr); end
    step(1'b1, 1'b1, 1'b0, 32'h0);
    n_vec++; if (out_pc !== 32'h40 || out_valid !== 1'b1) begin n_err++; $display("FAIL mis_fetch got v=%b pc=%h want 1/40", out_valid, out_pc); end
    step(1'b1, 1'b1, 1'b1, 32'h40);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    n_vec++; if (misalign_err !== 1'b1) begin n_err++; $display("FAIL mis_sticky got %b want 1", misalign_err); end
  endtask

  task automatic test_range();
    mem[1023] = 32'hABCD_0001;
    step(1'b1, 1'b1, 1'b1, 32'hFFC);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    n_vec++; if (out_pc !== 32'hFFC || imem_addr !== 32'h1000 || halted !== 1'b0) begin
      n_err++; $display("FAIL rng_last got pc=%h addr=%h h=%b want ffc/1000/0", out_pc, imem_addr, halted);
    end
    step(1'b1, 1'b1, 1'b0, 32'h0);
    n_vec++; if (halted !== 1'b1 || range_err !== 1'b1 || imem_addr !== 32'h1000 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL rng_halt got h=%b r=%b addr=%h v=%b want 1/1/1000/0", halted, range_err, imem_addr, out_valid);
    end
    step(1'b1, 1'b1, 1'b1, 32'h0);
    n_vec++; if (halted !== 1'b0 || range_err !== 1'b1 || imem_addr !== 32'h0) begin
      n_err++; $display("FAIL rng_resume got h=%b r=%b addr=%h want 0/1/0", halted, range_err, imem_addr);
    end
    step(1'b1, 1'b1, 1'b0, 32'h0);
    n_vec++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || range_err !== 1'b1) begin
      n_err++; $display("FAIL rng_refetch got v=%b pc=%h r=%b want 1/0/1", out_valid, out_pc, range_err);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 10; i++) mem[i] = 32'h2000_0000 + 32'(i);
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    n_vec++; if (fetch_count !== 32'd7 || out_valid !== 1'b1 || out_pc !== 32'h14) begin
      n_err++; $display("FAIL ar_pre got cnt=%0d v=%b pc=%h want 7/1/14", fetch_count, out_valid, out_pc);
    end
    #2;
    reset = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b0 || fetch_count !== 32'h0 || halted !== 1'b0 || imem_addr !== RESET_PC) begin
      n_err++; $display("FAIL ar_async got v=%b cnt=%0d h=%b addr=%h want 0/0/0/%h", out_valid, fetch_count, halted, imem_addr, RESET_PC);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    step(1'b1, 1'b1, 1'b0, 32'h0);
    n_vec++; if (out_valid !== 1'b1 || out_pc !== RESET_PC || out_instr !== 32'h2000_0000) begin
      n_err++; $display("FAIL ar_restart got v=%b pc=%h i=%h want 1/%h/20000000", out_valid, out_pc, out_instr, RESET_PC);
    end
  endtask

  task automatic test_random();
    logic [31:0] w, tgt, epc, ein;
    bit fe, rdy, rv;
    for (int i = 0; i < MEM_WORDS; i++) begin
      w = $urandom;
      if (w == 32'h0) w = 32'h1;
      if ($urandom_range(0, 15) == 0) w = 32'h0;
      mem[i] = w;
    end
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      fe  = ($urandom_range(0, 9) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0: begin w = $urandom_range(0, MEM_WORDS - 1); tgt = w * 4; end
        1: tgt = 32'hFF0 + 32'($urandom_range(0, 3) * 4);
        2: tgt = 32'($urandom_range(0, 4095));
        default: tgt = 32'h2000 + 32'($urandom_range(0, 15));
      endcase
      step(fe, rdy, rv, tgt);
      epc = (m_q.size() > 0) ? m_q[0][63:32] : 32'h0;
      ein = (m_q.size() > 0) ? m_q[0][31:0]  : 32'h0;
      n_vec++; if ({out_valid, halted, misalign_err, range_err} !== {m_q.size() > 0, m_halt, m_mis, m_rng}) begin
        n_err++; $display("FAIL rnd_flags c=%0d got %b want %b", c, {out_valid, halted, misalign_err, range_err}, {m_q.size() > 0, m_halt, m_mis, m_rng});
      end
      n_vec++; if (out_pc !== epc || out_instr !== ein) begin
        n_err++; $display("FAIL rnd_head c=%0d got %h/%h want %h/%h", c, out_pc, out_instr, epc, ein);
      end
      n_vec++; if (imem_addr !== m_pc || fetch_count !== m_cnt) begin
        n_err++; $display("FAIL rnd_pc_cnt c=%0d got %h/%0d want %h/%0d", c, imem_addr, fetch_count, m_pc, m_cnt);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_flush();
    test_misalign();
    test_range();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Sequences the word-addressed instruction memory (1024 x 32, combinational read, byte PC in, word PC/4 internally).
- Owns the program counter, issues one fetch per cycle, buffers fetched words in a small queue, and hands {pc, instruction} to decode over a valid/ready handshake.
- Handles branch redirects with a queue flush.
- Stops fetching on an all-zero word (unprogrammed memory) or an out-of-range PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 2, fetch queue entries (power of two, 2..8).
- MEM_WORDS, 1024, instruction memory size in words; PC/4 >= MEM_WORDS is out of range.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_en  in  1  1 = fetch allowed this cycle; 0 = hold PC, no enqueue.
- imem_addr  out  32  byte address to instruction memory; equals pc combinationally.
- imem_data  in  32  instruction word returned by memory in the same cycle.
- out_valid  out  1  queue head is valid.
- out_ready  in  1  decode accepts the head.
- out_instr  out  32  instruction at queue head.
- out_pc  out  32  byte PC of that instruction.
- redirect_valid  in  1  branch taken; fetch resumes at redirect_target.
- redirect_target  in  32  new byte PC.
- halted  out  1  state is HALT.
- misalign_err  out  1  sticky: a redirect target had bits [1:0] != 0.
- range_err  out  1  sticky: halt was caused by an out-of-range PC.
- fetch_count  out  32  number of instructions enqueued since reset, wraps.

Behaviour:
- Reset (async, any time including mid-operation):
  - pc = RESET_PC; queue empty; state RUN.
  - out_valid=0; halted=0; misalign_err=0; range_err=0; fetch_count=0.
  - out_instr and out_pc read as 0 while empty.
- States: RUN and HALT.
  - RUN -> HALT when a fetch attempt sees imem_data==0 or pc/4 >= MEM_WORDS.
  - HALT -> RUN only on redirect_valid (or reset).
- Pop: out_valid && out_ready at the clock edge removes the head. Head and count update on that edge.
- Fetch attempt (RUN, fetch_en=1, redirect_valid=0, and (count<DEPTH or pop this cycle)):
  - Out-of-range pc: no enqueue; state HALT; range_err=1; pc held.
  - Else if imem_data==32'h0: no enqueue; state HALT; pc held (pc keeps pointing at the zero word).
  - Else: enqueue {pc, imem_data} at the tail; pc = pc+4 (mod 2^32); fetch_count += 1.
- Full with no pop: no fetch, pc held, memory output ignored.
- Simultaneous push and pop when count==DEPTH: allowed, count unchanged.
- Redirect (highest priority, overrides pop, fetch and halt):
  - Next edge: queue flushed to count 0; pc = {redirect_target[31:2], 2'b00}; state RUN; no enqueue that cycle.
  - A head presented that cycle is discarded even if out_ready=1; decode must not consume it.
  - If redirect_target[1:0] != 0, misalign_err is set (sticky until reset).
- Latency:
  - First out_valid appears 1 cycle after the fetch edge; redirect-to-first-valid is 2 edges.
  - Steady-state throughput is 1 instruction/cycle when out_ready is held 1.
- Queue: circular, read and write pointers of log2(DEPTH) bits wrap naturally; count is log2(DEPTH)+1 bits.
- Outputs are registered or derived from registers, except imem_addr, which is a combinational copy of pc.

Test Plan:
1. Reset, memory holds words 0..3 = 32'hF8400281, 32'h8B010022, 32'hD1006733, 32'hB40000E3, remainder zero; fetch_en=1, out_ready=1 -> out_pc 0,4,8,12 on consecutive cycles with matching out_instr; then halted=1 with pc=16, fetch_count=4, range_err=0.
2. out_ready=0 for 5 cycles, DEPTH=2 -> two entries buffered (pc 0,4), imem_addr held at 8, fetch_count=2; out_ready=1 -> pc 0,4,8 delivered back-to-back with no gap or duplicate.
3. Redirect target 32'h40 while queue holds 2 entries and out_ready=1 -> next cycle out_valid=0, pc=0x40; following cycle out_pc=0x40; flushed entries never reappear.
4. Redirect target 32'h42 -> misalign_err=1 and stays 1; fetch proceeds from 0x40.
5. Redirect to 32'hFFC with MEM_WORDS=1024 -> fetch of 0xFFC succeeds, pc=0x1000, then halted=1 and range_err=1; a later redirect to 0 -> halted=0, fetch resumes, range_err remains 1.
6. Assert reset mid-stream with 2 queued entries and fetch_count=7 -> immediately (asynchronously) out_valid=0, fetch_count=0, halted=0, imem_addr=RESET_PC; after release, fetching restarts from RESET_PC.
